calc1_op_scheduler: RTL and testbench

- Shares the single add/sub unit and the single shift unit between the four calc1 request ports.
- Each port that has captured both operands posts one request carrying its command.
- The scheduler keeps one FIFO of port IDs per unit and issues one-cycle grants in strict arrival order.
- It sits between the per-port command/operand capture pipes and the two execution units. Invalid commands are bounced back to the requesting port.

---
 rtl/calc1_op_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_calc1_op_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_op_scheduler.sv
// calc1_op_scheduler
//   Shares the single add/sub unit and the single shift unit among the calc1
//   request ports. Each unit has its own FIFO of port IDs, and grants are issued
//   in strict arrival order. Invalid commands are bounced back with a one-cycle
//   inv_resp pulse.
//
//   Optional feature macro: CALC1_SCHED_ROTATE_EN
//     defined   : same-cycle pushes are ordered from a rotating priority pointer
//     undefined : same-cycle pushes are ordered by ascending port (port 1 first)
//
// Ports
//   c_clk, reset           clock, asynchronous active-high reset
//   req_valid[p-1]         one-cycle request pulse from port p
//   req_cmd                per-port command, port p at [(p-1)*CMD_W +: CMD_W]
//   arith_ready            add/sub unit can accept an op this cycle
//   shift_ready            shift unit can accept an op this cycle
//   arith_grant            one-hot add/sub grant (combinational from FIFO head)
//   shift_grant            one-hot shift grant (combinational from FIFO head)
//   arith_gnt_id           binary ID of arith_grant, 0 when idle
//   shift_gnt_id           binary ID of shift_grant, 0 when idle
//   inv_resp               one-cycle pulse, command was invalid
//   dup_err                sticky, a port requested while already outstanding
//   arith_count            add/sub FIFO occupancy
//   shift_count            shift FIFO occupancy
module calc1_op_scheduler #(
   parameter int unsigned NPORTS = 4,
   parameter int unsigned CMD_W  = 4,
   parameter int unsigned ID_W   = 2
) (
   input  logic                    c_clk,
   input  logic                    reset,
   input  logic [0:NPORTS-1]       req_valid,
   input  logic [0:NPORTS*CMD_W-1] req_cmd,
   input  logic                    arith_ready,
   input  logic                    shift_ready,
   output logic [0:NPORTS-1]       arith_grant,
   output logic [0:NPORTS-1]       shift_grant,
   output logic [ID_W-1:0]         arith_gnt_id,
   output logic [ID_W-1:0]         shift_gnt_id,
   output logic [0:NPORTS-1]       inv_resp,
   output logic                    dup_err,
   output logic [ID_W:0]           arith_count,
   output logic [ID_W:0]           shift_count
);

   localparam int unsigned CNT_W = ID_W + 1;

   localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(1);
   localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(2);
   localparam logic [CMD_W-1:0] CMD_LSH = CMD_W'(5);
   localparam logic [CMD_W-1:0] CMD_RSH = CMD_W'(6);

   typedef logic [ID_W-1:0] id_t;

   // State
   id_t               arith_fifo_q [NPORTS];
   id_t               arith_fifo_d [NPORTS];
   id_t               shift_fifo_q [NPORTS];
   id_t               shift_fifo_d [NPORTS];
   logic [CNT_W-1:0]  arith_count_q, arith_count_d;
   logic [CNT_W-1:0]  shift_count_q, shift_count_d;
   logic [0:NPORTS-1] outstanding_q, outstanding_d;
   logic [0:NPORTS-1] inv_resp_q, inv_resp_d;
   logic              dup_err_q, dup_err_d;
`ifdef CALC1_SCHED_ROTATE_EN
   id_t               rot_q, rot_d;
   logic [CNT_W-1:0]  n_push_c;
   id_t               first_push_c;
`endif

   // Per-port decode
   logic [CMD_W-1:0]  cmd_c [NPORTS];
   logic [0:NPORTS-1] dup_c;
   logic [0:NPORTS-1] push_a_c;
   logic [0:NPORTS-1] push_s_c;
   logic [0:NPORTS-1] inv_c;
   id_t               order_c [NPORTS];
   logic              arith_pop_c;
   logic              shift_pop_c;

   assign arith_pop_c = (arith_count_q != '0) && arith_ready;
   assign shift_pop_c = (shift_count_q != '0) && shift_ready;

   // Grants come straight from the FIFO heads so the unit sees them with zero delay
   always_comb begin
      arith_grant  = '0;
      shift_grant  = '0;
      arith_gnt_id = '0;
      shift_gnt_id = '0;
      if (arith_pop_c) begin
         arith_grant[arith_fifo_q[0]] = 1'b1;
         arith_gnt_id                 = arith_fifo_q[0];
      end
      if (shift_pop_c) begin
         shift_grant[shift_fifo_q[0]] = 1'b1;
         shift_gnt_id                 = shift_fifo_q[0];
      end
   end

   // Command decode; a port being granted this cycle may re-request without a dup
   always_comb begin
      for (int i = 0; i < int'(NPORTS); i++) begin
         cmd_c[i]    = req_cmd[i*CMD_W +: CMD_W];
         dup_c[i]    = req_valid[i] && outstanding_q[i] && !(arith_grant[i] || shift_grant[i]);
         push_a_c[i] = req_valid[i] && !dup_c[i] && (cmd_c[i] == CMD_ADD || cmd_c[i] == CMD_SUB);
         push_s_c[i] = req_valid[i] && !dup_c[i] && (cmd_c[i] == CMD_LSH || cmd_c[i] == CMD_RSH);
         inv_c[i]    = req_valid[i] && !dup_c[i] && !push_a_c[i] && !push_s_c[i];
      end
   end

   // Enqueue order for same-cycle pushes
   always_comb begin
      for (int k = 0; k < int'(NPORTS); k++) begin
`ifdef CALC1_SCHED_ROTATE_EN
         if (int'(rot_q) + k >= int'(NPORTS)) order_c[k] = ID_W'(int'(rot_q) + k - int'(NPORTS));
         else                                 order_c[k] = ID_W'(int'(rot_q) + k);
`else
         order_c[k] = ID_W'(k);
`endif
      end
   end

   // FIFO next state: pop shifts the queue down, then pushes append at the tail
   always_comb begin
      arith_fifo_d  = arith_fifo_q;
      shift_fifo_d  = shift_fifo_q;
      arith_count_d = arith_count_q;
      shift_count_d = shift_count_q;

      if (arith_pop_c) begin
         for (int i = 0; i < int'(NPORTS) - 1; i++) arith_fifo_d[i] = arith_fifo_q[i+1];
         arith_fifo_d[NPORTS-1] = '0;
         arith_count_d          = arith_count_q - CNT_W'(1);
      end
      if (shift_pop_c) begin
         for (int i = 0; i < int'(NPORTS) - 1; i++) shift_fifo_d[i] = shift_fifo_q[i+1];
         shift_fifo_d[NPORTS-1] = '0;
         shift_count_d          = shift_count_q - CNT_W'(1);
      end

      // One outstanding request per port keeps the tail index below NPORTS
      for (int k = 0; k < int'(NPORTS); k++) begin
         if (push_a_c[order_c[k]]) begin
            arith_fifo_d[arith_count_d[ID_W-1:0]] = order_c[k];
            arith_count_d                         = arith_count_d + CNT_W'(1);
         end
         if (push_s_c[order_c[k]]) begin
            shift_fifo_d[shift_count_d[ID_W-1:0]] = order_c[k];
            shift_count_d                         = shift_count_d + CNT_W'(1);
         end
      end
   end

`ifdef CALC1_SCHED_ROTATE_EN
   // Pointer moves past the first port pushed whenever two or more ports pushed
   always_comb begin
      n_push_c     = '0;
      first_push_c = '0;
      rot_d        = rot_q;
      for (int k = 0; k < int'(NPORTS); k++) begin
         if (push_a_c[order_c[k]] || push_s_c[order_c[k]]) begin
            if (n_push_c == '0) first_push_c = order_c[k];
            n_push_c = n_push_c + CNT_W'(1);
         end
      end
      if (n_push_c >= CNT_W'(2)) begin
         if (int'(first_push_c) == int'(NPORTS) - 1) rot_d = '0;
         else                                        rot_d = first_push_c + ID_W'(1);
      end
   end
`endif

   // Flags and responses
   always_comb begin
      outstanding_d = (outstanding_q & ~(arith_grant | shift_grant)) | push_a_c | push_s_c;
      inv_resp_d    = inv_c;
      dup_err_d     = dup_err_q || (|dup_c);
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(NPORTS); i++) begin
            arith_fifo_q[i] <= '0;
            shift_fifo_q[i] <= '0;
         end
         arith_count_q <= '0;
         shift_count_q <= '0;
         outstanding_q <= '0;
         inv_resp_q    <= '0;
         dup_err_q     <= 1'b0;
`ifdef CALC1_SCHED_ROTATE_EN
         rot_q         <= '0;
`endif
      end else begin
         arith_fifo_q  <= arith_fifo_d;
         shift_fifo_q  <= shift_fifo_d;
         arith_count_q <= arith_count_d;
         shift_count_q <= shift_count_d;
         outstanding_q <= outstanding_d;
         inv_resp_q    <= inv_resp_d;
         dup_err_q     <= dup_err_d;
`ifdef CALC1_SCHED_ROTATE_EN
         rot_q         <= rot_d;
`endif
      end
   end

   assign arith_count = arith_count_q;
   assign shift_count = shift_count_q;
   assign inv_resp    = inv_resp_q;
   assign dup_err     = dup_err_q;

endmodule

// File: tb/tb_calc1_op_scheduler.sv
// Directed testbench for calc1_op_scheduler: fixed vectors, hand-computed expectations.
module tb_calc1_op_scheduler;

   logic        c_clk;
   logic        reset;
   logic [0:3]  req_valid;
   logic [0:15] req_cmd;
   logic        arith_ready;
   logic        shift_ready;
   logic [0:3]  arith_grant;
   logic [0:3]  shift_grant;
   logic [1:0]  arith_gnt_id;
   logic [1:0]  shift_gnt_id;
   logic [0:3]  inv_resp;
   logic        dup_err;
   logic [2:0]  arith_count;
   logic [2:0]  shift_count;

   int n_checks = 0;
   int n_fail   = 0;

   calc1_op_scheduler #(.NPORTS(4), .CMD_W(4), .ID_W(2)) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_cmd      (req_cmd),
      .arith_ready  (arith_ready),
      .shift_ready  (shift_ready),
      .arith_grant  (arith_grant),
      .shift_grant  (shift_grant),
      .arith_gnt_id (arith_gnt_id),
      .shift_gnt_id (shift_gnt_id),
      .inv_resp     (inv_resp),
      .dup_err      (dup_err),
      .arith_count  (arith_count),
      .shift_count  (shift_count)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // p is 1-based
   task automatic set_req(input int p, input logic [3:0] cmd);
      req_valid[p-1]       = 1'b1;
      req_cmd[(p-1)*4 +: 4] = cmd;
   endtask

   task automatic clr_req();
      req_valid = '0;
      req_cmd   = '0;
   endtask

   // Step to 1 time unit after the next rising edge
   task automatic cyc();
      @(posedge c_clk);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      arith_ready = 1'b1;
      shift_ready = 1'b1;
      clr_req();
      repeat (2) @(posedge c_clk);
      #1 reset = 1'b0;
      #1;
      chk("rst_agrant", 32'(arith_grant), 32'h0);
      chk("rst_sgrant", 32'(shift_grant), 32'h0);
      chk("rst_aid",    32'(arith_gnt_id), 32'h0);
      chk("rst_acount", 32'(arith_count), 32'h0);
      chk("rst_scount", 32'(shift_count), 32'h0);
      chk("rst_inv",    32'(inv_resp), 32'h0);
      chk("rst_dup",    32'(dup_err), 32'h0);

      // Single ADD from port 2, latency 1
      set_req(2, 4'd1);
      cyc(); clr_req(); #1;
      chk("t1_agrant", 32'(arith_grant), 32'(4'b0100));
      chk("t1_aid",    32'(arith_gnt_id), 32'd1);
      chk("t1_acount", 32'(arith_count), 32'd1);
      cyc(); #1;
      chk("t1_acount0", 32'(arith_count), 32'd0);
      chk("t1_agrant0", 32'(arith_grant), 32'h0);

      // Ports 1,3,4 ADD on the same edge -> ascending order
      set_req(1, 4'd1); set_req(3, 4'd1); set_req(4, 4'd1);
      cyc(); clr_req(); #1;
      chk("t2_g1",  32'(arith_grant), 32'(4'b1000));
      chk("t2_c1",  32'(arith_count), 32'd3);
      chk("t2_sg1", 32'(shift_grant), 32'h0);
      cyc(); #1;
      chk("t2_g3",  32'(arith_grant), 32'(4'b0010));
      chk("t2_id3", 32'(arith_gnt_id), 32'd2);
      chk("t2_sg3", 32'(shift_grant), 32'h0);
      cyc(); #1;
      chk("t2_g4",  32'(arith_grant), 32'(4'b0001));
      chk("t2_id4", 32'(arith_gnt_id), 32'd3);
      chk("t2_sg4", 32'(shift_grant), 32'h0);
      cyc(); #1;
      chk("t2_gend", 32'(arith_grant), 32'h0);
      chk("t2_cend", 32'(arith_count), 32'd0);

      // Port 1 SUB and port 2 RSH -> both units grant in the same cycle
      set_req(1, 4'd2); set_req(2, 4'd6);
      cyc(); clr_req(); #1;
      chk("t3_agrant", 32'(arith_grant), 32'(4'b1000));
      chk("t3_sgrant", 32'(shift_grant), 32'(4'b0100));
      chk("t3_aid",    32'(arith_gnt_id), 32'd0);
      chk("t3_sid",    32'(shift_gnt_id), 32'd1);
      cyc(); #1;
      chk("t3_idle_a", 32'(arith_grant), 32'h0);
      chk("t3_idle_s", 32'(shift_grant), 32'h0);

      // Invalid command from port 4
      set_req(4, 4'd3);
      cyc(); clr_req(); #1;
      chk("t4_inv",    32'(inv_resp), 32'(4'b0001));
      chk("t4_acount", 32'(arith_count), 32'd0);
      chk("t4_scount", 32'(shift_count), 32'd0);
      chk("t4_agrant", 32'(arith_grant), 32'h0);
      chk("t4_sgrant", 32'(shift_grant), 32'h0);
      cyc(); #1;
      chk("t4_inv_end", 32'(inv_resp), 32'h0);

      // Re-request in the grant cycle is queued, not a duplicate
      set_req(3, 4'd1);
      cyc(); clr_req(); #1;
      chk("t5_g1", 32'(arith_grant), 32'(4'b0010));
      set_req(3, 4'd2);
      cyc(); clr_req(); #1;
      chk("t5_g2",  32'(arith_grant), 32'(4'b0010));
      chk("t5_cnt", 32'(arith_count), 32'd1);
      chk("t5_dup", 32'(dup_err), 32'd0);
      cyc(); #1;
      chk("t5_end", 32'(arith_count), 32'd0);

      // Port 1 LSH held by shift_ready=0, then duplicate request
      shift_ready = 1'b0;
      set_req(1, 4'd5);
      cyc(); clr_req(); #1;
      chk("t6_scount", 32'(shift_count), 32'd1);
      for (int i = 0; i < 4; i++) begin
         cyc(); #1;
         chk("t6_hold", 32'(shift_grant), 32'h0);
      end
      set_req(1, 4'd5);
      cyc(); clr_req(); #1;
      chk("t6_dup",    32'(dup_err), 32'd1);
      chk("t6_scount2", 32'(shift_count), 32'd1);
      shift_ready = 1'b1;
      #1;
      chk("t6_grant", 32'(shift_grant), 32'(4'b1000));
      chk("t6_sid",   32'(shift_gnt_id), 32'd0);
      cyc(); #1;
      chk("t6_once",  32'(shift_grant), 32'h0);
      chk("t6_empty", 32'(shift_count), 32'd0);
      chk("t6_sticky", 32'(dup_err), 32'd1);

      // Arrival order wins over port order while ready is low
      arith_ready = 1'b0;
      set_req(4, 4'd1); cyc(); clr_req();
      set_req(2, 4'd1); cyc(); clr_req();
      set_req(1, 4'd2); cyc(); clr_req(); #1;
      chk("t7_cnt",  32'(arith_count), 32'd3);
      chk("t7_none", 32'(arith_grant), 32'h0);
      arith_ready = 1'b1;
      #1;
      chk("t7_g4", 32'(arith_grant), 32'(4'b0001));
      chk("t7_i4", 32'(arith_gnt_id), 32'd3);
      cyc(); #1;
      chk("t7_g2", 32'(arith_grant), 32'(4'b0100));
      cyc(); #1;
      chk("t7_g1", 32'(arith_grant), 32'(4'b1000));
      cyc(); #1;
      chk("t7_end", 32'(arith_count), 32'd0);

      // Reset mid-operation drops queued requests
      arith_ready = 1'b0;
      set_req(1, 4'd1); set_req(2, 4'd1); set_req(3, 4'd2); set_req(4, 4'd2);
      cyc(); clr_req(); #1;
      chk("t8_full", 32'(arith_count), 32'd4);
      reset = 1'b1;
      #1;
      chk("t8_async", 32'(arith_count), 32'd0);
      cyc();
      reset       = 1'b0;
      arith_ready = 1'b1;
      #1;
      chk("t8_cnt",   32'(arith_count), 32'd0);
      chk("t8_grant", 32'(arith_grant), 32'h0);
      chk("t8_dup",   32'(dup_err), 32'd0);
      cyc(); #1;
      chk("t8_grant2", 32'(arith_grant), 32'h0);

      // Tie ordering: ports 1 and 2 twice (rotation moves port 2 first the second time)
      set_req(1, 4'd1); set_req(2, 4'd1);
      cyc(); clr_req(); #1;
      chk("t9_a1", 32'(arith_grant), 32'(4'b1000));
      cyc(); #1;
      chk("t9_a2", 32'(arith_grant), 32'(4'b0100));
      cyc(); #1;
      chk("t9_idle", 32'(arith_grant), 32'h0);
      set_req(1, 4'd1); set_req(2, 4'd1);
      cyc(); clr_req(); #1;
`ifdef CALC1_SCHED_ROTATE_EN
      chk("t9_b1", 32'(arith_grant), 32'(4'b0100));
      cyc(); #1;
      chk("t9_b2", 32'(arith_grant), 32'(4'b1000));
`else
      chk("t9_b1", 32'(arith_grant), 32'(4'b1000));
      cyc(); #1;
      chk("t9_b2", 32'(arith_grant), 32'(4'b0100));
`endif
      cyc(); #1;
      chk("t9_end", 32'(arith_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
